// File: rtl/adder_launch_capture.sv
// Launch/capture wrapper around a combinational adder under test.
// Registers operands, waits SETTLE_CYCLES, captures and checks the sum.
module adder_launch_capture #(
    parameter int WIDTH         = 9,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_mismatch,
    input  logic             i_clr_err,
    output logic [ERR_W-1:0] o_err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t state;
    state_t state_nxt;

    logic [3:0]     cnt;
    logic [WIDTH:0] golden;
    logic [WIDTH:0] captured;
    logic           accept;
    logic           capture;
    logic           drain;
    logic           bad;

    assign captured = {i_cout, i_sum};
    assign bad      = (captured != golden);

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        drain     = 1'b0;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    drain     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands only move on an accept, keeping the adder inputs quiet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_add_term1 <= '0;
            o_add_term2 <= '0;
            golden      <= '0;
        end else if (accept) begin
            o_add_term1 <= i_a;
            o_add_term2 <= i_b;
            golden      <= {1'b0, i_a} + {1'b0, i_b};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if (state == SETTLE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result   <= '0;
            o_mismatch <= 1'b0;
            o_valid    <= 1'b0;
        end else if (capture) begin
            o_result   <= captured;
            o_mismatch <= bad;
            o_valid    <= 1'b1;
        end else if (drain) begin
            o_valid    <= 1'b0;
        end
    end

    // Clear takes priority over a same-edge increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_count <= '0;
        end else if (i_clr_err) begin
            o_err_count <= '0;
        end else if (capture && bad && o_err_count != ERR_MAX) begin
            o_err_count <= o_err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_launch_capture.sv
// Scoreboard bench for adder_launch_capture with a behavioural adder
// whose sum LSB can be inverted to provoke mismatches.
module tb_adder_launch_capture;

    localparam int W     = 9;
    localparam int SC    = 2;
    localparam int EW    = 2;
    localparam int EMAX  = 3;

    typedef struct {
        logic [W:0] res;
        logic       mis;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic [W-1:0]  term1;
    logic [W-1:0]  term2;
    logic [W-1:0]  sum;
    logic          cout;
    logic          o_valid;
    logic          i_ready;
    logic [W:0]    o_result;
    logic          o_mismatch;
    logic          clr_err;
    logic [EW-1:0] err_count;

    logic          fault;
    logic [W:0]    adder_out;

    exp_t q[$];
    int   acc_log[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   exp_err = 0;
    logic prev_valid = 1'b0;
    logic prev_clr   = 1'b0;

    always #5 clk = ~clk;

    // Adder under test: correct unless the bench injects a fault on bit 0.
    assign adder_out = ({1'b0, term1} + {1'b0, term2}) ^ {{W{1'b0}}, fault};
    assign {cout, sum} = adder_out;

    adder_launch_capture #(
        .WIDTH(W),
        .SETTLE_CYCLES(SC),
        .ERR_W(EW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a(i_a),
        .i_b(i_b),
        .o_add_term1(term1),
        .o_add_term2(term2),
        .i_sum(sum),
        .i_cout(cout),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_result(o_result),
        .o_mismatch(o_mismatch),
        .i_clr_err(clr_err),
        .o_err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Monitor: push on accept, pop on result handshake, track error count.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_err    = 0;
            prev_valid = 1'b0;
            prev_clr   = 1'b0;
        end else begin
            cyc++;
            if (prev_clr)
                exp_err = 0;
            else if (o_valid && !prev_valid && q.size() != 0 && q[0].mis
                     && exp_err != EMAX)
                exp_err++;
            if (o_valid && !prev_valid) begin
                check("capture_has_txn", 32'(q.size() != 0), 1);
                if (q.size() != 0)
                    check("latency", cyc - q[0].cyc, SC + 1);
                check("err_count", 32'(err_count), exp_err);
            end
            if (o_valid && i_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'(o_result), 32'(e.res));
                check("mismatch", 32'(o_mismatch), 32'(e.mis));
            end
            if (i_valid && o_ready) begin
                exp_t e;
                e.res = ({1'b0, i_a} + {1'b0, i_b}) ^ {{W{1'b0}}, fault};
                e.mis = fault;
                e.cyc = cyc;
                q.push_back(e);
                acc_log.push_back(cyc);
            end
            prev_valid = o_valid;
            prev_clr   = clr_err;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic f);
        bit ok = 0;
        i_a = a;
        i_b = b;
        fault = f;
        i_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (o_ready) ok = 1;
        end
        check("accept_timeout", 32'(ok), 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("term1", 32'(term1), 32'(a));
        check("term2", 32'(term2), 32'(b));
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && q.size() != 0; k++)
            @(negedge clk);
        check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_ready = 1'b1;
        clr_err = 1'b0;
        fault   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_result", 32'(o_result), 0);
        check("rst_term1", 32'(term1), 0);
        check("rst_err", 32'(err_count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic
        send(9'h0FF, 9'h001, 1'b0);
        wait_done();
        check("basic_valid_low", 32'(o_valid), 0);
        check("basic_ready", 32'(o_ready), 1);

        // Max operands, back-to-back accepts
        acc_log.delete();
        i_a = 9'h1FF;
        i_b = 9'h1FF;
        fault = 1'b0;
        i_valid = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_done();
        check("b2b_count", acc_log.size(), 4);
        for (int k = 1; k < acc_log.size(); k++)
            check("b2b_interval", acc_log[k] - acc_log[k-1], SC + 2);

        // Backpressure with operand churn
        i_ready = 1'b0;
        send(9'h0A5, 9'h05A, 1'b0);
        for (int k = 0; k < 20 && !o_valid; k++)
            @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(o_valid), 1);
            check("bp_ready", 32'(o_ready), 0);
            check("bp_result", 32'(o_result), 32'h0FF);
            check("bp_term1", 32'(term1), 32'h0A5);
            @(posedge clk);
            #1;
            i_a = W'($urandom);
            i_b = W'($urandom);
        end
        i_ready = 1'b1;
        wait_done();

        // Fault injection
        send(9'd3, 9'd4, 1'b1);
        wait_done();
        check("fault_err", 32'(err_count), 1);
        send(9'd5, 9'd6, 1'b0);
        wait_done();
        check("fault_err_hold", 32'(err_count), 1);

        // Saturation, then clear colliding with an increment
        for (int k = 0; k < 5; k++) begin
            send(W'(k * 17), W'(k + 40), 1'b1);
            wait_done();
        end
        check("sat_err", 32'(err_count), EMAX);
        send(9'd1, 9'd1, 1'b1);
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_wins", 32'(err_count), 0);
        wait_done();

        // Reset while in SETTLE
        send(9'h055, 9'h0AA, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("mid_rst_ready", 32'(o_ready), 1);
        check("mid_rst_valid", 32'(o_valid), 0);
        check("mid_rst_term1", 32'(term1), 0);
        check("mid_rst_term2", 32'(term2), 0);
        check("mid_rst_result", 32'(o_result), 0);
        check("mid_rst_mis", 32'(o_mismatch), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(o_valid), 0);
        end
        @(posedge clk);
        #1;
        send(9'h010, 9'h020, 1'b0);
        wait_done();
        check("post_rst_ready", 32'(o_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
